checkpoint_seq_monitor: RTL and testbench
=========================================

# checkpoint_seq_monitor

Parametrised, synthesizable checkpoint-sequence monitor. It watches a DATA_W-bit status field, such as the 16-bit mprj_io[31:16] checkbits field, for a programmed ordered list of expected values. It reports pass, fail, or timeout together with the elapsed cycle count. It generalises the fixed wait-chain used by the LA/matmul firmware benches into reusable RTL for both the user project and bench harnesses: programmable depth, value width, timeout, debounce and strict-order checking.

## Interface
Parameters:
- DATA_W, 16, width of observed field and of each expected value
- DEPTH, 8, maximum number of checkpoints (power of two, ≥2); IDX_W = $clog2(DEPTH)
- CNT_W, 33, cycle counter width; must satisfy 2^CNT_W > TIMEOUT
- TIMEOUT, 200000, cycles from start after which an incomplete sequence fails
- STABLE, 2, consecutive cycles a value must hold to count as a match (≥1)
- STRICT, 1, 1 = a stable value equal to any non-current programmed entry is an out-of-order failure

Ports:
- clock  in  1  sole clock, rising edge
- RSTB  in  1  asynchronous active-low reset
- checkbits  in  DATA_W  observed field
- prog_we  in  1  write expected-value table entry
- prog_addr  in  IDX_W  table index
- prog_data  in  DATA_W  expected value
- num_checks  in  IDX_W+1  checkpoints in sequence (0..DEPTH), sampled on start
- start  in  1  one-cycle pulse: arm and begin sequence
- clear  in  1  synchronous return to IDLE, clears status
- busy  out  1  sequence in progress
- pass  out  1  sticky pass
- fail  out  1  sticky fail
- fail_code  out  2  00 none, 01 timeout, 10 out-of-order
- index  out  IDX_W+1  checkpoints matched so far
- match_pulse  out  1  one-cycle pulse per accepted checkpoint
- cycle_count  out  CNT_W  cycles since start; frozen on pass/fail

## Operation
- Reset: all outputs 0, FSM = IDLE. The expected-value table is not reset; it is undefined until programmed.
- FSM states: IDLE, RUN, PASS, FAIL.
- IDLE
  - prog_we writes table[prog_addr].
  - start latches num_checks, zeroes index and cycle_count, and enters RUN.
  - If num_checks = 0, start enters PASS directly.
- RUN
  - busy = 1, cycle_count increments every cycle.
  - Stability tracker: a counter resets whenever the observed value changes; it saturates at STABLE.
  - A value becomes "stable" on the cycle the counter reaches STABLE. Each stable event is evaluated once.
  - Stable event equal to table[index]: match_pulse, index+1. If index+1 = num_checks, enter PASS.
  - Stable event equal to table[j], j≠index, j<num_checks, with STRICT=1: enter FAIL, fail_code=10.
  - Any other stable value is ignored.
  - If cycle_count reaches TIMEOUT-1 with no completion: enter FAIL, fail_code=01.
- PASS/FAIL
  - Sticky; pass/fail held, cycle_count and index frozen.
  - start is ignored; only clear or reset exits.
- Boundary and priority rules:
  - prog_we outside IDLE is ignored.
  - start while busy is ignored.
  - clear has priority over start and over match in the same cycle.
  - Final match and timeout in the same cycle → PASS; match wins.
  - Duplicate consecutive expected values need the field to leave and re-settle before the second match. The tracker re-arms only on a value change.
  - Reset mid-sequence aborts immediately to IDLE with outputs 0.
  - cycle_count never wraps, because the timeout fires first.

## Timing
- The observed value is checkbits after the optional synchronizer (see Configuration): SYNC_LAT = 2 cycles with the synchronizer, 0 without.
- A checkbits change settled before edge k produces match_pulse after edge k+SYNC_LAT+STABLE-1, registered.
- pass/fail assert on the same edge as the final match_pulse or the failing event.
- cycle_count = 0 in the cycle after start and equals the RUN cycle number thereafter.
- busy falls on the same edge that pass/fail rises.

## Configuration
- Macro CHKMON_SYNC_EN.
- Defined: checkbits passes through a two-flop synchronizer (reset to 0) before stability tracking. Required when the source is asynchronous pad data. SYNC_LAT = 2.
- Undefined: checkbits feeds the tracker directly (same-clock on-chip source). SYNC_LAT = 0.

## Test plan
- Program [AB40, 003E, 0044, 004A, 0050, AB51], num_checks=6, start, drive each value for 10 cycles → six match_pulses, index=6, pass=1, fail_code=00, cycle_count frozen at the final-match cycle.
- Same table, stop after 0044, TIMEOUT=1000 → fail=1, fail_code=01 at cycle_count=999, index=3.
- STRICT=1: drive AB40 then 0044 → fail, fail_code=10, index=1. STRICT=0: same stimulus → no fail; later 003E, 0044, ... still passes.
- STABLE=2: glitch 003E for 1 cycle after AB40 → no match_pulse. Hold it 2 cycles → match exactly SYNC_LAT+1 cycles after the edge.
- num_checks=0 with start → pass=1 one cycle later, busy never 1.
- Deassert RSTB mid-RUN → all outputs 0 asynchronously. After release, a new start runs cleanly. clear and start in the same cycle → IDLE.

Source files
------------

// File: rtl/checkpoint_seq_monitor.sv
// Checkpoint-sequence monitor: matches a stable observed field against a programmed ordered table
// and reports pass / fail (timeout or out-of-order) with elapsed cycles. Define CHKMON_SYNC_EN for a 2-flop input synchronizer.
module checkpoint_seq_monitor #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 33,
    parameter int TIMEOUT = 200000,
    parameter int STABLE  = 2,
    parameter int STRICT  = 1,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              RSTB,
    input  logic [DATA_W-1:0] checkbits,
    input  logic              prog_we,
    input  logic [IDX_W-1:0]  prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic [IDX_W:0]    num_checks,
    input  logic              start,
    input  logic              clear,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [IDX_W:0]    index,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int               ST_W     = $clog2(STABLE + 1);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STABLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]   CHK_MAX  = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;
    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_TIMEOUT = 2'b01,
        FC_ORDER   = 2'b10
    } fcode_t;

    state_t            state_q, state_d;
    fcode_t            code_q, code_d;
    logic [IDX_W:0]    index_q, index_d, num_q, num_d, idx_inc;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              match_q, match_d;

    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [DATA_W-1:0] obs, prev_q;
    logic [ST_W-1:0]   stab_q, stab_d;
    logic              same, stable_evt, hit_cur, hit_other, timed_out;

`ifdef CHKMON_SYNC_EN
    logic [DATA_W-1:0] sync1_q, sync2_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= checkbits;
            sync2_q <= sync1_q;
        end
    end
    assign obs = sync2_q;
`else
    assign obs = checkbits;
`endif

    // Stability tracker: restarts at 1 on any change, saturates at STABLE; the event fires once on arrival.
    assign same = (obs == prev_q);

    always_comb begin
        stab_d = stab_q;
        if (!same)
            stab_d = ST_W'(1);
        else if (stab_q != ST_MAX)
            stab_d = stab_q + 1'b1;
    end

    assign stable_evt = (stab_d == ST_MAX) && ((stab_q != ST_MAX) || !same);

    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            prev_q <= '0;
            stab_q <= '0;
        end else begin
            prev_q <= obs;
            stab_q <= stab_d;
        end
    end

    // NOTE: the expected-value table is plain storage with no reset; it is only meaningful once programmed.
    always_ff @(posedge clock) begin
        if (prog_we && state_q == S_IDLE)
            exp_mem[prog_addr] <= prog_data;
    end

    assign hit_cur   = (obs == exp_mem[index_q[IDX_W-1:0]]);
    assign idx_inc   = index_q + 1'b1;
    assign timed_out = (count_q == CNT_LAST);

    always_comb begin
        hit_other = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (((IDX_W + 1)'(j) < num_q) && ((IDX_W + 1)'(j) != index_q) && (exp_mem[j] == obs))
                hit_other = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        code_d  = code_q;
        index_d = index_q;
        num_d   = num_q;
        count_d = count_q;
        match_d = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            code_d  = FC_NONE;
            index_d = '0;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_d   = (num_checks > CHK_MAX) ? CHK_MAX : num_checks;
                        index_d = '0;
                        count_d = '0;
                        code_d  = FC_NONE;
                        state_d = (num_checks == '0) ? S_PASS : S_RUN;
                    end
                end
                S_RUN: begin
                    // A final match beats a coincident timeout; the count freezes on any terminal edge.
                    if (stable_evt && hit_cur) begin
                        match_d = 1'b1;
                        index_d = idx_inc;
                        if (idx_inc == num_q) begin
                            state_d = S_PASS;
                        end else if (timed_out) begin
                            state_d = S_FAIL;
                            code_d  = FC_TIMEOUT;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end else if (stable_evt && hit_other && (STRICT != 0)) begin
                        state_d = S_FAIL;
                        code_d  = FC_ORDER;
                    end else if (timed_out) begin
                        state_d = S_FAIL;
                        code_d  = FC_TIMEOUT;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= S_IDLE;
            code_q  <= FC_NONE;
            index_q <= '0;
            num_q   <= '0;
            count_q <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            index_q <= index_d;
            num_q   <= num_d;
            count_q <= count_d;
            match_q <= match_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign pass        = (state_q == S_PASS);
    assign fail        = (state_q == S_FAIL);
    assign fail_code   = code_q;
    assign index       = index_q;
    assign match_pulse = match_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Directed bench for checkpoint_seq_monitor: a scoreboard queue of expected match pulses plus
// status checks; a strict and a lax instance share the same stimulus.
module tb_checkpoint_seq_monitor;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 8;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 33;
    localparam int TIMEOUT = 1000;
    localparam int STABLE  = 2;
`ifdef CHKMON_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        int cyc;
        int idx;
    } exp_match_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] checkbits;
    logic              prog_we;
    logic [IDX_W-1:0]  prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [IDX_W:0]    num_checks;
    logic              start, clear;

    logic              busy, pass, fail, match_pulse;
    logic [1:0]        fail_code;
    logic [IDX_W:0]    index;
    logic [CNT_W-1:0]  cycle_count;

    logic              l_busy, l_pass, l_fail, l_match;
    logic [1:0]        l_code;
    logic [IDX_W:0]    l_index;
    logic [CNT_W-1:0]  l_count;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int s_cyc, final_cyc, midx, mnum, waited;
    bit model_run = 1'b0;
    logic [DATA_W-1:0] last_v;
    logic [DATA_W-1:0] mtab [DEPTH];
    logic [DATA_W-1:0] vals [6];
    exp_match_t sb[$];
    exp_match_t em;

    checkpoint_seq_monitor #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W),
        .TIMEOUT(TIMEOUT), .STABLE(STABLE), .STRICT(1)
    ) u_dut (
        .clock(clk), .RSTB(rst_n), .checkbits(checkbits),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .num_checks(num_checks), .start(start), .clear(clear),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .index(index), .match_pulse(match_pulse), .cycle_count(cycle_count)
    );

    checkpoint_seq_monitor #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W),
        .TIMEOUT(TIMEOUT), .STABLE(STABLE), .STRICT(0)
    ) u_lax (
        .clock(clk), .RSTB(rst_n), .checkbits(checkbits),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .num_checks(num_checks), .start(start), .clear(clear),
        .busy(l_busy), .pass(l_pass), .fail(l_fail), .fail_code(l_code),
        .index(l_index), .match_pulse(l_match), .cycle_count(l_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] dut_outs();
        return 64'({busy, pass, fail, fail_code, index, match_pulse, cycle_count});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int a, input logic [DATA_W-1:0] d);
        prog_we   = 1'b1;
        prog_addr = IDX_W'(a);
        prog_data = d;
        step();
        prog_we   = 1'b0;
        mtab[a]   = d;
    endtask

    // Hold v for n cycles; a value that settles, differs from the last one and is the next entry yields a match.
    task automatic drive_for(input logic [DATA_W-1:0] v, input int n);
        checkbits = v;
        if (model_run && n >= STABLE && v !== last_v && v == mtab[midx]) begin
            sb.push_back('{cyc: cyc + SYNC_LAT + STABLE, idx: midx + 1});
            midx++;
            if (midx == mnum) begin
                model_run = 1'b0;
                final_cyc = cyc + SYNC_LAT + STABLE;
            end
        end
        last_v = v;
        repeat (n) step();
    endtask

    task automatic do_start(input int nc);
        num_checks = (IDX_W + 1)'(nc);
        start      = 1'b1;
        step();
        start      = 1'b0;
        s_cyc      = cyc;
        midx       = 0;
        mnum       = nc;
        model_run  = (nc != 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear     = 1'b0;
        model_run = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && match_pulse === 1'b1) begin
            check("match_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                em = sb.pop_front();
                check("match_cycle", 64'(cyc), 64'(em.cyc));
                check("match_index", 64'(index), 64'(em.idx));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vals = '{16'hAB40, 16'h003E, 16'h0044, 16'h004A, 16'h0050, 16'hAB51};
        rst_n = 1'b0; checkbits = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        num_checks = '0; start = 1'b0; clear = 1'b0; last_v = '0;
        repeat (3) step();
        check("reset_outputs", dut_outs(), 64'd0);
        rst_n = 1'b1;
        step();

        // Full in-order sequence
        for (int i = 0; i < 6; i++) prog(i, vals[i]);
        drive_for(16'h0000, 3);
        do_start(6);
        check("t1_busy_after_start", 64'({busy, pass, fail}), 64'b100);
        check("t1_count_after_start", 64'(cycle_count), 64'd0);
        for (int i = 0; i < 6; i++) drive_for(vals[i], 10);
        check("t1_queue_drained", 64'(sb.size()), 64'd0);
        check("t1_index", 64'(index), 64'd6);
        check("t1_status", 64'({busy, pass, fail, fail_code}), 64'b01000);
        check("t1_frozen_count", 64'(cycle_count), 64'(final_cyc - 1 - s_cyc));
        check("t1_lax_pass", 64'({l_pass, l_index}), 64'({1'b1, 4'd6}));
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t1_start_ignored", 64'({busy, pass, cycle_count}), 64'({1'b0, 1'b1, 33'(final_cyc - 1 - s_cyc)}));

        // Timeout after three checkpoints
        do_clear();
        check("t2_clear_status", dut_outs(), 64'd0);
        drive_for(16'h0000, 3);
        do_start(6);
        for (int i = 0; i < 3; i++) drive_for(vals[i], 10);
        check("t2_run_count", 64'(cycle_count), 64'(cyc - s_cyc));
        check("t2_busy", 64'({busy, pass, fail}), 64'b100);
        model_run = 1'b0;
        drive_for(16'h0000, 1);
        waited = 0;
        while (fail !== 1'b1 && waited < TIMEOUT + 100) begin
            step();
            waited++;
        end
        check("t2_fail_edge", 64'(cyc - s_cyc), 64'(TIMEOUT));
        check("t2_status", 64'({busy, pass, fail, fail_code}), 64'b00101);
        check("t2_count", 64'(cycle_count), 64'(TIMEOUT - 1));
        check("t2_index", 64'(index), 64'(midx));
        repeat (3) step();
        check("t2_count_frozen", 64'(cycle_count), 64'(TIMEOUT - 1));

        // Out-of-order value: strict instance fails, lax instance carries on
        do_clear();
        drive_for(16'h0000, 3);
        do_start(6);
        drive_for(vals[0], 10);
        model_run = 1'b0;
        drive_for(vals[2], 10);
        check("t3_strict_status", 64'({busy, pass, fail, fail_code, index}), 64'({3'b001, 2'b10, 4'd1}));
        check("t3_lax_running", 64'({l_busy, l_fail, l_index}), 64'({2'b10, 4'd1}));
        for (int i = 1; i < 6; i++) drive_for(vals[i], 10);
        check("t3_lax_pass", 64'({l_pass, l_fail, l_code, l_index}), 64'({2'b10, 2'b00, 4'd6}));
        check("t3_strict_sticky", 64'({fail, fail_code, index}), 64'({1'b1, 2'b10, 4'd1}));

        // One-cycle glitch is rejected, a two-cycle hold matches
        do_clear();
        drive_for(16'h0000, 3);
        do_start(6);
        drive_for(vals[0], 10);
        drive_for(vals[1], 1);
        drive_for(16'h0000, 1);
        drive_for(16'h0000, 4);
        check("t4_glitch_ignored", 64'(index), 64'd1);
        drive_for(vals[1], 2);
        drive_for(16'h0000, 4);
        check("t4_hold_matched", 64'({busy, index}), 64'({1'b1, 4'd2}));
        check("t4_queue_drained", 64'(sb.size()), 64'd0);

        // Empty sequence passes straight away
        do_clear();
        do_start(0);
        check("t5_pass_now", 64'({busy, pass, fail, index}), 64'({3'b010, 4'd0}));
        step();
        check("t5_still_pass", 64'({busy, pass, cycle_count}), 64'({2'b01, 33'd0}));

        // Asynchronous reset mid-run, then a clean rerun on the retained table
        do_clear();
        drive_for(16'h0000, 3);
        do_start(6);
        drive_for(vals[0], 10);
        drive_for(vals[1], 1);
        check("t6_queue_empty", 64'(sb.size()), 64'd0);
        #2 rst_n = 1'b0;
        #1 check("t6_async_reset", dut_outs(), 64'd0);
        checkbits = '0;
        last_v    = '0;
        model_run = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("t6_after_release", dut_outs(), 64'd0);
        drive_for(16'h0000, 3);
        do_start(6);
        for (int i = 0; i < 6; i++) drive_for(vals[i], 10);
        check("t6_rerun_pass", 64'({pass, fail, index}), 64'({2'b10, 4'd6}));
        check("t6_rerun_count", 64'(cycle_count), 64'(final_cyc - 1 - s_cyc));

        // clear wins over a simultaneous start
        do_clear();
        clear = 1'b1;
        start = 1'b1;
        num_checks = 4'd6;
        step();
        clear = 1'b0;
        start = 1'b0;
        step();
        check("t7_clear_beats_start", dut_outs(), 64'd0);

        // Duplicate consecutive entries; table writes while running are ignored
        prog(0, 16'h1111);
        prog(1, 16'h1111);
        drive_for(16'h0000, 3);
        do_start(2);
        prog_we = 1'b1; prog_addr = 3'd1; prog_data = 16'h2222;
        step();
        prog_we = 1'b0;
        drive_for(16'h1111, 6);
        check("t8_one_match_on_hold", 64'(index), 64'd1);
        drive_for(16'h0000, 3);
        drive_for(16'h1111, 3);
        drive_for(16'h0000, 2);
        check("t8_dup_pass", 64'({pass, fail, index}), 64'({2'b10, 4'd2}));
        check("t8_queue_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
